// File: rtl/sram_port_arb.sv
// Arbiter sharing one single-port 4-lane SRAM between the IFU fetch port and the LSU data port.
// LSU has priority unless the IFU has been denied STARVE_MAX cycles in a row.
module sram_port_arb #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ifu_req,
    input  logic [AW-1:0] ifu_a,
    output logic          ifu_gnt,
    output logic          ifu_rvld,
    output logic [31:0]   ifu_rd,
    input  logic          lsu_req,
    input  logic          lsu_we,
    input  logic [3:0]    lsu_be,
    input  logic [AW-1:0] lsu_a,
    input  logic [31:0]   lsu_wd,
    output logic          lsu_gnt,
    output logic          lsu_rvld,
    output logic [31:0]   lsu_rd,
    output logic          sram_e,
    output logic [3:0]    sram_we,
    output logic [AW-3:0] sram_a,
    output logic [31:0]   sram_wd,
    input  logic [31:0]   sram_rd
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } own_e;

    own_e       rd_own_q, rd_own_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       ifu_pri;
    logic       unused_addr_lsb;

    // Byte-offset bits are meaningless for a word-wide SRAM.
    assign unused_addr_lsb = ^{ifu_a[1:0], lsu_a[1:0]};

    always_comb begin
        ifu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        ifu_pri = (starve_cnt_q == 4'(STARVE_MAX));
        if (!rst) begin
            if (ifu_pri) begin
                if (ifu_req)      ifu_gnt = 1'b1;
                else if (lsu_req) lsu_gnt = 1'b1;
            end else begin
                if (lsu_req)      lsu_gnt = 1'b1;
                else if (ifu_req) ifu_gnt = 1'b1;
            end
        end
    end

    assign sram_e  = ifu_gnt | lsu_gnt;
    assign sram_a  = ifu_gnt ? ifu_a[AW-1:2] : lsu_a[AW-1:2];
    assign sram_wd = lsu_gnt ? lsu_wd : 32'h0;
    assign sram_we = (lsu_gnt && lsu_we) ? lsu_be : 4'b0000;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (rst || ifu_gnt)
            starve_cnt_d = 4'd0;
        else if (ifu_req && (starve_cnt_q < 4'(STARVE_MAX)))
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    // Remember who owns the read data that the SRAM returns next cycle.
    always_comb begin
        rd_own_d = OWN_NONE;
        if (ifu_gnt)
            rd_own_d = OWN_IFU;
        else if (lsu_gnt && !lsu_we)
            rd_own_d = OWN_LSU;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            rd_own_q     <= OWN_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_own_q     <= rd_own_d;
        end
    end

    // Gating with rst drops a read granted just before reset asserted.
    assign ifu_rvld = (rd_own_q == OWN_IFU) && !rst;
    assign lsu_rvld = (rd_own_q == OWN_LSU) && !rst;
    assign ifu_rd   = sram_rd;
    assign lsu_rd   = sram_rd;

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: vector table plus starvation sequence, with an SRAM model
// and a scoreboard of expected read responses.
module tb_sram_port_arb;
    localparam int AW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, ifu_gnt, ifu_rvld;
    logic [15:0] ifu_a;
    logic [31:0] ifu_rd;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvld;
    logic [3:0]  lsu_be;
    logic [15:0] lsu_a;
    logic [31:0] lsu_wd, lsu_rd;
    logic        sram_e;
    logic [3:0]  sram_we;
    logic [13:0] sram_a;
    logic [31:0] sram_wd;
    logic [31:0] sram_rd;

    always #5 clk = ~clk;

    sram_port_arb #(.AW(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_a(ifu_a), .ifu_gnt(ifu_gnt), .ifu_rvld(ifu_rvld), .ifu_rd(ifu_rd),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_a(lsu_a), .lsu_wd(lsu_wd),
        .lsu_gnt(lsu_gnt), .lsu_rvld(lsu_rvld), .lsu_rd(lsu_rd),
        .sram_e(sram_e), .sram_we(sram_we), .sram_a(sram_a), .sram_wd(sram_wd), .sram_rd(sram_rd)
    );

    typedef struct {
        logic        rs;
        logic        ir;
        logic [15:0] ia;
        logic        lr;
        logic        lw;
        logic [3:0]  lbe;
        logic [15:0] la;
        logic [31:0] lwd;
        logic        eig;
        logic        elg;
        logic [3:0]  ewe;
    } vec_t;

    typedef struct {
        logic        is_ifu;
        logic [31:0] data;
    } rsp_t;

    vec_t        vecs[$];
    rsp_t        sb[$];
    logic [31:0] mem[256];
    logic [31:0] exp_mem[256];
    int          n_checks = 0;
    int          n_fail = 0;

    // SRAM macro model: one-cycle registered read, per-lane writes.
    always @(posedge clk) begin
        if (sram_e) begin
            if (sram_we == 4'b0000)
                sram_rd <= mem[sram_a[7:0]];
            else
                for (int i = 0; i < 4; i++)
                    if (sram_we[i]) mem[sram_a[7:0]][8*i +: 8] <= sram_wd[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic void add(input logic rs, input logic ir, input logic [15:0] ia,
                                input logic lr, input logic lw, input logic [3:0] lbe,
                                input logic [15:0] la, input logic [31:0] lwd,
                                input logic eig, input logic elg, input logic [3:0] ewe);
        vecs.push_back('{rs, ir, ia, lr, lw, lbe, la, lwd, eig, elg, ewe});
    endfunction

    task automatic step(input vec_t v, input int idx);
        rsp_t        r;
        logic [13:0] exp_a;
        logic [7:0]  w;
        @(negedge clk);
        rst = v.rs; ifu_req = v.ir; ifu_a = v.ia;
        lsu_req = v.lr; lsu_we = v.lw; lsu_be = v.lbe; lsu_a = v.la; lsu_wd = v.lwd;
        #1;
        if (v.rs) begin
            sb.delete();
            chk("ifu_rvld_rst", {31'h0, ifu_rvld}, 32'h0);
            chk("lsu_rvld_rst", {31'h0, lsu_rvld}, 32'h0);
        end else if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("ifu_rvld", {31'h0, ifu_rvld}, {31'h0, r.is_ifu});
            chk("lsu_rvld", {31'h0, lsu_rvld}, {31'h0, !r.is_ifu});
            chk(r.is_ifu ? "ifu_rd" : "lsu_rd", r.is_ifu ? ifu_rd : lsu_rd, r.data);
        end else begin
            chk("ifu_rvld_idle", {31'h0, ifu_rvld}, 32'h0);
            chk("lsu_rvld_idle", {31'h0, lsu_rvld}, 32'h0);
        end
        chk("ifu_gnt", {31'h0, ifu_gnt}, {31'h0, v.eig});
        chk("lsu_gnt", {31'h0, lsu_gnt}, {31'h0, v.elg});
        chk("sram_e", {31'h0, sram_e}, {31'h0, v.eig | v.elg});
        chk("sram_we", {28'h0, sram_we}, {28'h0, v.ewe});
        if (v.eig || v.elg) begin
            exp_a = v.eig ? v.ia[15:2] : v.la[15:2];
            chk("sram_a", {18'h0, sram_a}, {18'h0, exp_a});
        end
        if (v.eig) begin
            sb.push_back('{1'b1, exp_mem[v.ia[9:2]]});
        end else if (v.elg && !v.lw) begin
            sb.push_back('{1'b0, exp_mem[v.la[9:2]]});
        end else if (v.elg && v.lw) begin
            w = v.la[9:2];
            for (int i = 0; i < 4; i++)
                if (v.lbe[i]) exp_mem[w][8*i +: 8] = v.lwd[8*i +: 8];
        end
        $display("txn %0d: rst=%b ifu_req=%b lsu_req=%b we=%b be=%b -> ifu_gnt=%b lsu_gnt=%b sram_we=%b ifu_rvld=%b lsu_rvld=%b",
                 idx, v.rs, v.ir, v.lr, v.lw, v.lbe, ifu_gnt, lsu_gnt, sram_we, ifu_rvld, lsu_rvld);
    endtask

    initial begin
        vec_t sv;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = {16'hC0DE, 8'h00, i[7:0]};
            mem[i]     = exp_mem[i];
        end
        exp_mem[4] = 32'h11223344;
        mem[4]     = 32'h11223344;
        sram_rd = 32'h0;
        rst = 1'b1; ifu_req = 1'b0; ifu_a = '0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = '0; lsu_a = '0; lsu_wd = '0;

        // reset holds grants low even with both requests up
        add(1, 1, 'h00, 1, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        add(1, 1, 'h00, 1, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        // IFU-only back-to-back fetches
        add(0, 1, 'h00, 0, 0, 4'h0, 'h00, 0, 1, 0, 4'h0);
        add(0, 1, 'h04, 0, 0, 4'h0, 'h00, 0, 1, 0, 4'h0);
        add(0, 1, 'h08, 0, 0, 4'h0, 'h00, 0, 1, 0, 4'h0);
        add(0, 0, 'h00, 0, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        // sub-word store then readback
        add(0, 0, 'h00, 1, 1, 4'b0101, 'h10, 32'hAABBCCDD, 0, 1, 4'b0101);
        add(0, 0, 'h00, 1, 0, 4'h0, 'h10, 0, 0, 1, 4'h0);
        add(0, 0, 'h00, 0, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        // alternating IFU / LSU / IFU reads
        add(0, 1, 'h20, 0, 0, 4'h0, 'h00, 0, 1, 0, 4'h0);
        add(0, 0, 'h00, 1, 0, 4'h0, 'h24, 0, 0, 1, 4'h0);
        add(0, 1, 'h28, 0, 0, 4'h0, 'h00, 0, 1, 0, 4'h0);
        add(0, 0, 'h00, 0, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        // be=0 write alongside IFU: consumes slot, no memory change
        add(0, 1, 'h44, 1, 1, 4'h0, 'h40, 32'hFFFFFFFF, 0, 1, 4'h0);
        add(0, 1, 'h44, 0, 0, 4'h0, 'h00, 0, 1, 0, 4'h0);
        add(0, 0, 'h00, 1, 0, 4'h0, 'h40, 0, 0, 1, 4'h0);
        add(0, 0, 'h00, 0, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        // reset right after an LSU read grant drops the response
        add(0, 0, 'h00, 1, 0, 4'h0, 'h0C, 0, 0, 1, 4'h0);
        add(1, 0, 'h00, 0, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        add(0, 0, 'h00, 0, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);
        add(0, 1, 'h00, 0, 0, 4'h0, 'h00, 0, 1, 0, 4'h0);
        add(0, 0, 'h00, 0, 0, 4'h0, 'h00, 0, 0, 0, 4'h0);

        foreach (vecs[i]) step(vecs[i], i);

        // continuous contention: LSU four cycles, then IFU once, repeating
        for (int k = 0; k < 10; k++) begin
            sv = '{1'b0, 1'b1, 16'h0034, 1'b1, 1'b0, 4'h0, 16'h0030, 32'h0,
                   logic'(k % 5 == 4), logic'(k % 5 != 4), 4'h0};
            step(sv, 100 + k);
        end
        sv = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0, 1'b0, 1'b0, 4'h0};
        step(sv, 110);
        step(sv, 111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
